ast_frame_ctrl: RTL and testbench
=================================

Name: ast_frame_ctrl

Overview:
- Frame-level sequencer for the camera plus ast_detector path, clocked in the camera receive domain.
- Issues periodic camera trigger pulses and applies threshold/enable config to the detector only between frames.
- Latches the detector's per-frame corner count after the pipeline drains.
- Flags overrun (period shorter than frame) and frame-start timeout.

Parameters:
- TRIG_CYCLES, 8, width of trigger pulse in clocks (>=1).
- DRAIN_CYCLES, 16, clocks after fv falls before qv_cnt is sampled.
- TIMEOUT_CYCLES, 1_000_000, max clocks from trigger to fv rise.
- PERIOD_W, 32, width of period counter.

Ports:
- c  in  1  clock (camera rx clock).
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  level; 1 = free-running triggering, 0 = stop after the current frame.
- cfg_period  in  PERIOD_W  trigger period in clocks; sampled at each trigger.
- cfg_t  in  8  detector threshold; shadowed.
- cfg_en  in  1  detector enable; shadowed.
- cfg_wr  in  1  one-cycle strobe; loads cfg_t/cfg_en into shadow registers.
- fv  in  1  frame valid from python_decoder.
- qv_cnt  in  16  running corner count from ast_detector.
- trigger  out  1  camera trigger.
- det_t  out  8  threshold to detector.
- det_en  out  1  enable to detector.
- frame_done  out  1  one-cycle pulse; frame_corners valid.
- frame_corners  out  16  latched corner count of last frame.
- frame_num  out  16  completed-frame counter; wraps 0xFFFF->0.
- overrun  out  1  sticky; period expired before frame finished.
- timeout  out  1  sticky; fv did not rise within TIMEOUT_CYCLES.
- clr_flags  in  1  one-cycle strobe; clears overrun and timeout.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async, rst_n=0): state IDLE; trigger 0; det_t 8'h10; det_en 0; frame_done 0; frame_corners 0; frame_num 0; overrun 0; timeout 0; shadow regs t=8'h10, en=0; all counters 0.
- fv is synchronous to c; a one-stage registered copy is used for edge detection. Rise and fall are each seen one cycle late.
- States:
  - IDLE: if run=1 -> ARM.
  - ARM (1 cycle): copy shadow to det_t/det_en; load period counter with cfg_period-1 (cfg_period=0 treated as 1); -> TRIG.
  - TRIG: trigger=1 for exactly TRIG_CYCLES clocks; timeout counter starts at trigger assertion; -> WAIT_FV.
  - WAIT_FV:
    - fv rise -> FRAME.
    - Timeout counter reaches TIMEOUT_CYCLES -> set timeout, then -> ARM if run else IDLE.
  - FRAME: fv fall -> DRAIN.
  - DRAIN: count DRAIN_CYCLES. On the last cycle latch frame_corners<=qv_cnt, pulse frame_done, increment frame_num -> GAP.
  - GAP:
    - run=0 -> IDLE.
    - Period counter already zero (expired during frame) -> set overrun, -> ARM next cycle.
    - Otherwise wait until the counter reaches 0, -> ARM.
- Period counter decrements every cycle from ARM, saturating at 0. Trigger-to-trigger spacing = max(cfg_period, frame duration + overhead) + 1 cycle (ARM).
- Shadow config:
  - cfg_wr in any state updates the shadow only.
  - det_t/det_en change only in ARM, so never mid-frame.
  - cfg_wr in the same cycle as ARM: the old shadow is applied; the new value is taken at the next ARM.
- run deasserted mid-frame: the frame completes, frame_done pulses, then IDLE. No new trigger.
- clr_flags in the same cycle as a flag set: the set wins.
- fv fall seen in WAIT_FV (spurious): ignored.
- fv already high on entry to WAIT_FV: no rise is detected, so the block waits for the next rise or the timeout.

Optional Feature:
- Macro: AST_FRAME_CTRL_LIMIT_EN.
- With it:
  - Adds input cfg_limit[15:0], shadowed and applied in ARM like cfg_t.
  - In FRAME and DRAIN, when qv_cnt >= limit and limit != 0, det_en drops to 0 for the rest of the frame and sticky output limited is set.
  - det_en is restored in the next ARM.
  - clr_flags also clears limited.
- Without it: no cfg_limit or limited ports; det_en is constant between ARMs.

Decomposition:
- Package ast_frame_ctrl_pkg:
  - state enum (IDLE, ARM, TRIG, WAIT_FV, FRAME, DRAIN, GAP).
  - default threshold constant 8'h10.
  - reset values.
- One natural sub-module, ast_frame_ctrl_timer: loadable down-counter with saturate-at-zero and done flag. Instantiated twice: period and timeout; the drain count reuses the timeout instance.

Test Plan:
- cfg_wr t=8'h20 en=1, run=1, cfg_period=20000, 64-row frame of 5000 clocks -> trigger high exactly 8 clocks; det_t=8'h20 from ARM; second trigger 20001 clocks after the first.
- Frame with a known 37 corners -> frame_done pulses once, 16 clocks after fv fall + 1; frame_corners=37; frame_num=1.
- cfg_period=100 with a 5000-clock frame -> overrun=1; next ARM the cycle after GAP entry; clr_flags -> overrun=0.
- Trigger with the sensor silent, TIMEOUT_CYCLES=1000 -> timeout=1 1000 clocks after the trigger rise; re-triggers; frame_num unchanged.
- cfg_wr t=8'h40 mid-frame -> det_t stays 8'h20 until the next ARM; run=0 mid-frame -> frame completes, then IDLE, no further trigger, busy=0.
- Assert rst_n low mid-FRAME -> all outputs at reset values asynchronously; det_en=0 immediately.

Source files
------------

// File: rtl/ast_frame_ctrl_pkg.sv
// Shared types and constants for the frame sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ast_frame_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARM     = 3'd1,
        TRIG    = 3'd2,
        WAIT_FV = 3'd3,
        FRAME   = 3'd4,
        DRAIN   = 3'd5,
        GAP     = 3'd6
    } state_t;

    // Detector threshold/enable used until the first cfg_wr.
    localparam logic [7:0]  DEF_T   = 8'h10;
    localparam logic        DEF_EN  = 1'b0;
    localparam logic [15:0] RST_CNT = 16'h0000;

endpackage

// File: rtl/ast_frame_ctrl_timer.sv
// Loadable down-counter that saturates at zero; done is high while the count is zero.
// Latency: load takes effect at the next edge; done follows the count combinationally.
// Backpressure: none; load is accepted every cycle and overrides counting.
module ast_frame_ctrl_timer
    import ast_frame_ctrl_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         c,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt;

    // Load has priority; otherwise count down and hold at zero.
    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/ast_frame_ctrl.sv
// Frame sequencer: periodic camera trigger, between-frame detector config, per-frame corner latch, overrun/timeout flags.
// Latency: trigger rises 2 clocks after run; frame_done pulses DRAIN_CYCLES+1 clocks after fv falls (fv edges seen 1 clock late).
// Backpressure: none; level/strobe inputs always accepted. Macro AST_FRAME_CTRL_LIMIT_EN adds cfg_limit/limited corner-limit gating.
module ast_frame_ctrl
    import ast_frame_ctrl_pkg::*;
#(
    parameter int TRIG_CYCLES    = 8,
    parameter int DRAIN_CYCLES   = 16,
    parameter int TIMEOUT_CYCLES = 1_000_000,
    parameter int PERIOD_W       = 32
) (
    input  logic                c,
    input  logic                rst_n,
    input  logic                run,
    input  logic [PERIOD_W-1:0] cfg_period,
    input  logic [7:0]          cfg_t,
    input  logic                cfg_en,
    input  logic                cfg_wr,
    input  logic                fv,
    input  logic [15:0]         qv_cnt,
`ifdef AST_FRAME_CTRL_LIMIT_EN
    input  logic [15:0]         cfg_limit,
    output logic                limited,
`endif
    output logic                trigger,
    output logic [7:0]          det_t,
    output logic                det_en,
    output logic                frame_done,
    output logic [15:0]         frame_corners,
    output logic [15:0]         frame_num,
    output logic                overrun,
    output logic                timeout,
    input  logic                clr_flags,
    output logic                busy
);

    localparam int TO_MAX = (TIMEOUT_CYCLES > DRAIN_CYCLES) ? TIMEOUT_CYCLES : DRAIN_CYCLES;
    localparam int TW     = $clog2(TO_MAX + 1);
    localparam int CW     = $clog2(TRIG_CYCLES + 1);
    localparam logic [TW-1:0] TO_LOAD   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] DR_LOAD   = TW'(DRAIN_CYCLES - 1);
    localparam logic [CW-1:0] TRIG_LOAD = CW'(TRIG_CYCLES - 1);

    state_t                state;
    logic                  fv_d;
    logic                  fv_rise;
    logic                  fv_fall;
    logic [7:0]            sh_t;
    logic                  sh_en;
    logic [CW-1:0]         trig_cnt;
    logic                  gap_first;
    logic                  per_load;
    logic                  per_done;
    logic [PERIOD_W-1:0]   per_val;
    logic                  to_load;
    logic                  to_done;
    logic [TW-1:0]         to_val;
`ifdef AST_FRAME_CTRL_LIMIT_EN
    logic [15:0]           sh_lim;
    logic [15:0]           lim;
`endif

    assign fv_rise = fv & ~fv_d;
    assign fv_fall = ~fv & fv_d;

    // Period restarts at every ARM; a zero period behaves like one.
    assign per_load = (state == ARM);
    assign per_val  = (cfg_period == '0) ? '0 : cfg_period - 1'b1;

    // One counter serves both the trigger-to-fv timeout and the post-frame drain.
    assign to_load  = (state == ARM) || ((state == FRAME) && fv_fall);
    assign to_val   = (state == ARM) ? TO_LOAD : DR_LOAD;

    assign busy     = (state != IDLE);

    ast_frame_ctrl_timer #(.W(PERIOD_W)) u_period (
        .c        (c),
        .rst_n    (rst_n),
        .load     (per_load),
        .load_val (per_val),
        .done     (per_done)
    );

    ast_frame_ctrl_timer #(.W(TW)) u_timeout (
        .c        (c),
        .rst_n    (rst_n),
        .load     (to_load),
        .load_val (to_val),
        .done     (to_done)
    );

    // fv history for edge detection, and the shadow config written at any time.
    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            fv_d   <= 1'b0;
            sh_t   <= DEF_T;
            sh_en  <= DEF_EN;
`ifdef AST_FRAME_CTRL_LIMIT_EN
            sh_lim <= RST_CNT;
`endif
        end else begin
            fv_d <= fv;
            if (cfg_wr) begin
                sh_t   <= cfg_t;
                sh_en  <= cfg_en;
`ifdef AST_FRAME_CTRL_LIMIT_EN
                sh_lim <= cfg_limit;
`endif
            end
        end
    end

    // Frame sequencer with registered outputs; flag sets are placed after clr so a same-cycle set wins.
    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            trigger       <= 1'b0;
            det_t         <= DEF_T;
            det_en        <= DEF_EN;
            frame_done    <= 1'b0;
            frame_corners <= RST_CNT;
            frame_num     <= RST_CNT;
            overrun       <= 1'b0;
            timeout       <= 1'b0;
            trig_cnt      <= '0;
            gap_first     <= 1'b0;
`ifdef AST_FRAME_CTRL_LIMIT_EN
            lim           <= RST_CNT;
            limited       <= 1'b0;
`endif
        end else begin
            frame_done <= 1'b0;
            if (clr_flags) begin
                overrun <= 1'b0;
                timeout <= 1'b0;
`ifdef AST_FRAME_CTRL_LIMIT_EN
                limited <= 1'b0;
`endif
            end
            case (state)
                IDLE: begin
                    if (run) state <= ARM;
                end
                ARM: begin
                    det_t    <= sh_t;
                    det_en   <= sh_en;
`ifdef AST_FRAME_CTRL_LIMIT_EN
                    lim      <= sh_lim;
`endif
                    trigger  <= 1'b1;
                    trig_cnt <= TRIG_LOAD;
                    state    <= TRIG;
                end
                TRIG: begin
                    if (trig_cnt == '0) begin
                        trigger <= 1'b0;
                        state   <= WAIT_FV;
                    end else begin
                        trig_cnt <= trig_cnt - 1'b1;
                    end
                end
                WAIT_FV: begin
                    if (fv_rise) begin
                        state <= FRAME;
                    end else if (to_done) begin
                        timeout <= 1'b1;
                        state   <= run ? ARM : IDLE;
                    end
                end
                FRAME: begin
                    if (fv_fall) state <= DRAIN;
                end
                DRAIN: begin
                    if (to_done) begin
                        frame_corners <= qv_cnt;
                        frame_done    <= 1'b1;
                        frame_num     <= frame_num + 1'b1;
                        gap_first     <= 1'b1;
                        state         <= GAP;
                    end
                end
                GAP: begin
                    gap_first <= 1'b0;
                    if (!run) begin
                        state <= IDLE;
                    end else if (per_done) begin
                        if (gap_first) overrun <= 1'b1;
                        state <= ARM;
                    end
                end
                default: state <= IDLE;
            endcase
`ifdef AST_FRAME_CTRL_LIMIT_EN
            if (((state == FRAME) || (state == DRAIN)) && (lim != '0) && (qv_cnt >= lim)) begin
                det_en  <= 1'b0;
                limited <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_ast_frame_ctrl.sv
// Randomized bench for ast_frame_ctrl with a scoreboard of expected triggers and frame completions.
// Latency: n/a.
// Backpressure: n/a.
module tb_ast_frame_ctrl;

    localparam int TRIG = 8;
    localparam int DR   = 16;
    localparam int TO   = 1000;
    localparam int NF   = 18;

    logic        c;
    logic        rst_n;
    logic        run;
    logic [31:0] cfg_period;
    logic [7:0]  cfg_t;
    logic        cfg_en;
    logic        cfg_wr;
    logic        fv;
    logic [15:0] qv_cnt;
    logic        trigger;
    logic [7:0]  det_t;
    logic        det_en;
    logic        frame_done;
    logic [15:0] frame_corners;
    logic [15:0] frame_num;
    logic        overrun;
    logic        timeout;
    logic        clr_flags;
    logic        busy;
`ifdef AST_FRAME_CTRL_LIMIT_EN
    logic [15:0] cfg_limit;
    logic        limited;
`endif

    ast_frame_ctrl #(
        .TRIG_CYCLES    (TRIG),
        .DRAIN_CYCLES   (DR),
        .TIMEOUT_CYCLES (TO),
        .PERIOD_W       (32)
    ) dut (
        .c             (c),
        .rst_n         (rst_n),
        .run           (run),
        .cfg_period    (cfg_period),
        .cfg_t         (cfg_t),
        .cfg_en        (cfg_en),
        .cfg_wr        (cfg_wr),
        .fv            (fv),
        .qv_cnt        (qv_cnt),
`ifdef AST_FRAME_CTRL_LIMIT_EN
        .cfg_limit     (cfg_limit),
        .limited       (limited),
`endif
        .trigger       (trigger),
        .det_t         (det_t),
        .det_en        (det_en),
        .frame_done    (frame_done),
        .frame_corners (frame_corners),
        .frame_num     (frame_num),
        .overrun       (overrun),
        .timeout       (timeout),
        .clr_flags     (clr_flags),
        .busy          (busy)
    );

    typedef struct {
        int         cyc;
        logic [7:0] t;
        logic       en;
        logic       ov;
        logic       to;
    } trig_rec_t;

    typedef struct {
        int          cyc;
        logic [15:0] corners;
        logic [15:0] num;
        logic [7:0]  t;
        logic        en;
    } done_rec_t;

    trig_rec_t trig_q[$];
    done_rec_t done_q[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Reference state: shadow config, sticky flags, completed frame count.
    logic [7:0]  sh_t   = 8'h10;
    logic        sh_en  = 1'b0;
    logic [7:0]  nxt_t  = 8'h10;
    logic        nxt_en = 1'b0;
    logic [7:0]  app_t  = 8'h10;
    logic        app_en = 1'b0;
    logic        ov_m   = 1'b0;
    logic        to_m   = 1'b0;
    logic [15:0] num_m  = 16'd0;

    initial begin
        c = 1'b0;
        forever #5 c = ~c;
    end

    initial begin
        forever begin
            @(posedge c);
            cyc++;
        end
    end

    initial begin
        repeat (90000) @(posedge c);
        n_cmp++;
        n_bad++;
        $display("FAIL watchdog: run still active at cycle %0d, limit 90000", cyc);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_trigger"}, trigger, 0);
        check({tag, "_det_t"}, det_t, 8'h10);
        check({tag, "_det_en"}, det_en, 0);
        check({tag, "_frame_done"}, frame_done, 0);
        check({tag, "_frame_corners"}, frame_corners, 0);
        check({tag, "_frame_num"}, frame_num, 0);
        check({tag, "_overrun"}, overrun, 0);
        check({tag, "_timeout"}, timeout, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    task automatic wait_trig(input int bound, output int r, output bit ok);
        logic prev;
        prev = trigger;
        ok   = 1'b0;
        r    = 0;
        for (int k = 0; k < bound; k++) begin
            @(negedge c);
            if (trigger && !prev) begin
                ok = 1'b1;
                r  = cyc;
                break;
            end
            prev = trigger;
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL trig_wait: no trigger rise within %0d cycles (cycle %0d)", bound, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT raises trigger or frame_done.
    initial begin : monitor
        logic      tprev;
        int        hi;
        trig_rec_t tr;
        done_rec_t dn;
        tprev = 1'b0;
        hi    = 0;
        forever begin
            @(negedge c);
            if (!rst_n) begin
                tprev = 1'b0;
                hi    = 0;
                continue;
            end
            if (trigger && !tprev) begin
                if (trig_q.size() == 0) begin
                    check("unexpected_trigger", cyc, 0);
                end else begin
                    tr = trig_q.pop_front();
                    check("trig_time", cyc, tr.cyc);
                    check("trig_det_t", det_t, tr.t);
                    check("trig_det_en", det_en, tr.en);
                    check("trig_overrun", overrun, tr.ov);
                    check("trig_timeout", timeout, tr.to);
                end
            end
            if (trigger) hi++;
            if (!trigger && tprev) begin
                check("trig_width", hi, TRIG);
                hi = 0;
            end
            tprev = trigger;
            if (frame_done) begin
                if (done_q.size() == 0) begin
                    check("unexpected_frame_done", cyc, 0);
                end else begin
                    dn = done_q.pop_front();
                    check("done_time", cyc, dn.cyc);
                    check("done_corners", frame_corners, dn.corners);
                    check("done_num", frame_num, dn.num);
                    check("done_det_t", det_t, dn.t);
                    check("done_det_en", det_en, dn.en);
                end
            end
        end
    end

    // Stimulus: sensor model answering each trigger with a frame (or silence) plus config traffic.
    initial begin : stim
        int          r;
        int          s;
        int          f;
        int          d;
        int          j;
        int          len;
        int          cur_p;
        int          p_this;
        bit          ok;
        bit          silent;
        bit          last;
        logic [15:0] n_c;

        rst_n      = 1'b0;
        run        = 1'b0;
        cfg_period = 32'd0;
        cfg_t      = 8'h00;
        cfg_en     = 1'b0;
        cfg_wr     = 1'b0;
        fv         = 1'b0;
        qv_cnt     = 16'd0;
        clr_flags  = 1'b0;
`ifdef AST_FRAME_CTRL_LIMIT_EN
        cfg_limit  = 16'd0;
`endif
        repeat (3) @(negedge c);
        check_reset_outputs("rst_held");
        rst_n = 1'b1;
        @(negedge c);
        check_reset_outputs("rst_rel");

        cfg_t  = 8'h20;
        cfg_en = 1'b1;
        cfg_wr = 1'b1;
        sh_t   = 8'h20;
        sh_en  = 1'b1;
        @(negedge c);
        cfg_wr = 1'b0;

        cur_p      = 20000;
        cfg_period = 32'd20000;
        @(negedge c);
        s   = cyc;
        run = 1'b1;
        // IDLE sees run on the next edge, ARM on the one after raises trigger.
        trig_q.push_back('{s + 2, sh_t, sh_en, ov_m, to_m});
        nxt_t  = sh_t;
        nxt_en = sh_en;

        for (int i = 0; i < NF; i++) begin
            wait_trig(25000, r, ok);
            if (!ok) break;
            app_t  = nxt_t;
            app_en = nxt_en;
            p_this = (cur_p == 0) ? 1 : cur_p;
            cur_p      = $urandom_range(0, 600);
            cfg_period = cur_p;
            silent = (i == 3) || (i == 9);
            last   = (i == NF - 1);

            if (i % 4 == 2) begin
                clr_flags = 1'b1;
                ov_m      = 1'b0;
                to_m      = 1'b0;
                @(negedge c);
                clr_flags = 1'b0;
            end

            if (silent) begin
                // No frame: timeout is flagged TO clocks after the trigger rise, then re-arm.
                to_m = 1'b1;
                trig_q.push_back('{r + TO + 1, sh_t, sh_en, ov_m, to_m});
                nxt_t  = sh_t;
                nxt_en = sh_en;
                continue;
            end

            j = $urandom_range(0, 30);
            while (cyc < r + TRIG + j) @(negedge c);
            fv     = 1'b1;
            qv_cnt = 16'd0;
            if (i == 0) begin
                len = 5000;
                n_c = 16'd37;
            end else begin
                len = $urandom_range(20, 300);
                n_c = 16'($urandom_range(0, 4000));
            end
            for (int k = 1; k < len; k++) begin
                @(negedge c);
                cfg_wr = 1'b0;
                qv_cnt = 16'((int'(n_c) * k) / len);
                if (k == len / 2) begin
                    if (i % 3 == 1) begin
                        cfg_t  = (i == 1) ? 8'h40 : 8'($urandom_range(0, 255));
                        cfg_en = 1'($urandom_range(0, 1));
                        cfg_wr = 1'b1;
                        sh_t   = cfg_t;
                        sh_en  = cfg_en;
                    end
                    if (last) run = 1'b0;
                end
            end
            @(negedge c);
            cfg_wr = 1'b0;
            fv     = 1'b0;
            qv_cnt = n_c;
            f      = cyc;
            d      = f + DR + 1;
            num_m  = num_m + 16'd1;
            done_q.push_back('{d, n_c, num_m, app_t, app_en});
            if (run) begin
                // Period count reaches zero P-1 clocks after the trigger rise; if that is no later
                // than the frame_done cycle, it is an overrun and ARM follows immediately.
                if (d >= r + p_this - 1) begin
                    ov_m = 1'b1;
                    trig_q.push_back('{d + 2, sh_t, sh_en, ov_m, to_m});
                end else begin
                    trig_q.push_back('{r + p_this + 1, sh_t, sh_en, ov_m, to_m});
                end
                nxt_t  = sh_t;
                nxt_en = sh_en;
            end
        end

        // run was dropped mid-frame: the frame finished, no further trigger, block idle.
        repeat (60) @(negedge c);
        check("stop_busy", busy, 0);
        check("stop_trigger", trigger, 0);
        check("stop_frame_num", frame_num, num_m);

        // Restart, then assert reset in the middle of a frame.
        s   = cyc;
        run = 1'b1;
        trig_q.push_back('{s + 2, sh_t, sh_en, ov_m, to_m});
        wait_trig(100, r, ok);
        repeat (TRIG + 4) @(negedge c);
        fv = 1'b1;
        repeat (20) @(negedge c);
        check("pre_rst_busy", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        fv  = 1'b0;
        run = 1'b0;
        @(negedge c);
        rst_n = 1'b1;
        repeat (3) @(negedge c);
        check("end_trig_q_empty", trig_q.size(), 0);
        check("end_done_q_empty", done_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
